// File: rtl/mcnc_bench_pkg.sv
// Shared types and constants for the mcnc combinational benchmark driver.
// Contents: FSM state enum, LFSR38 / MISR16 tap masks, default LFSR seed.
package mcnc_bench_pkg;

    localparam int unsigned LFSR_WIDTH = 38;
    localparam int unsigned SIG_WIDTH  = 16;

    // Feedback taps: LFSR bits 37,5,4,0; MISR bits 15,14,12,3
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS    = 38'h20_0000_0031;
    localparam logic [SIG_WIDTH-1:0]  MISR_TAPS    = 16'hD008;
    localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 38'h1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mcnc_misr.sv
// Multiple-input signature register compacting benchmark responses.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en),
//        en (absorb din this edge), din (response), sig (signature state).
module mcnc_misr
    import mcnc_bench_pkg::*;
#(
    parameter int unsigned MISR_WIDTH = 16,
    parameter int unsigned PO_WIDTH   = 3,
    parameter logic [MISR_WIDTH-1:0] TAPS = MISR_WIDTH'(MISR_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PO_WIDTH-1:0]   din,
    output logic [MISR_WIDTH-1:0] sig
);

    logic fb;

    assign fb = ^(sig & TAPS);

    // Shift with feedback, then fold in the zero-extended response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[MISR_WIDTH-2:0], fb} ^ MISR_WIDTH'(din);
        end
    end

endmodule

// File: rtl/mcnc_pattern_driver.sv
// Drives N LFSR vectors into a combinational benchmark and compacts the responses.
// Ports: clk, rst_n (async active-low), start, num_vectors, seed (sampled on accept),
//        pi (registered vector out), po (benchmark response in), busy, done,
//        signature (MISR state), vec_count (responses captured this run).
module mcnc_pattern_driver
    import mcnc_bench_pkg::*;
#(
    parameter int unsigned PI_WIDTH   = 38,
    parameter int unsigned PO_WIDTH   = 3,
    parameter int unsigned MISR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_vectors,
    input  logic [PI_WIDTH-1:0]   seed,
    output logic [PI_WIDTH-1:0]   pi,
    input  logic [PO_WIDTH-1:0]   po,
    output logic                  busy,
    output logic                  done,
    output logic [MISR_WIDTH-1:0] signature,
    output logic [CNT_WIDTH-1:0]  vec_count
);

    localparam logic [PI_WIDTH-1:0] TAPS = PI_WIDTH'(LFSR_TAPS);

    state_t               state_q, state_d;
    logic [PI_WIDTH-1:0]  lfsr_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] n_q;
    logic [PO_WIDTH-1:0]  po_q;
    logic                 po_v;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 capture;
    logic                 advance;
    logic                 drain;
    logic                 lfsr_fb;

    assign lfsr_fb = ^(lfsr_q & TAPS);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        drain   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                capture = 1'b1;
                // Last capture keeps the final vector on pi; count lands exactly on N
                if (cnt_q == n_q - CNT_WIDTH'(1)) begin
                    state_d = DRAIN;
                end else begin
                    advance = 1'b1;
                end
            end
            DRAIN: begin
                drain   = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Vector generator, response capture, counter and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
            cnt_q  <= '0;
            n_q    <= '0;
            po_q   <= '0;
            po_v   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d == RUN) || (state_d == DRAIN);
            done_q <= (state_d == DONE);
            if (accept) begin
                lfsr_q <= (seed == '0) ? PI_WIDTH'(DEFAULT_SEED) : seed;
                cnt_q  <= '0;
                n_q    <= num_vectors;
                po_v   <= 1'b0;
            end else if (capture) begin
                po_q  <= po;
                po_v  <= 1'b1;
                cnt_q <= cnt_q + CNT_WIDTH'(1);
                if (advance) begin
                    lfsr_q <= {lfsr_q[PI_WIDTH-2:0], lfsr_fb};
                end
            end else if (drain) begin
                po_v <= 1'b0;
            end
        end
    end

    mcnc_misr #(
        .MISR_WIDTH (MISR_WIDTH),
        .PO_WIDTH   (PO_WIDTH)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (po_v),
        .din   (po_q),
        .sig   (signature)
    );

    assign pi        = lfsr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_mcnc_pattern_driver.sv
// Self-checking bench for mcnc_pattern_driver with a stub benchmark po = pi[2:0].
module tb_mcnc_pattern_driver;

    localparam int unsigned PIW = 38;
    localparam int unsigned POW = 3;
    localparam int unsigned MW  = 16;
    localparam int unsigned CW  = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [CW-1:0]  num_vectors;
    logic [PIW-1:0] seed;
    logic [PIW-1:0] pi;
    logic [POW-1:0] po;
    logic           busy;
    logic           done;
    logic [MW-1:0]  signature;
    logic [CW-1:0]  vec_count;

    int checks = 0;
    int errors = 0;

    mcnc_pattern_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_vectors (num_vectors),
        .seed        (seed),
        .pi          (pi),
        .po          (po),
        .busy        (busy),
        .done        (done),
        .signature   (signature),
        .vec_count   (vec_count)
    );

    assign po = pi[2:0];

    always #5 clk = ~clk;

    // Reference polynomials written directly from the tap lists
    function automatic logic [PIW-1:0] ref_lfsr(input logic [PIW-1:0] x);
        return {x[36:0], x[37] ^ x[5] ^ x[4] ^ x[0]};
    endfunction

    function automatic logic [MW-1:0] ref_misr(input logic [MW-1:0] m, input logic [POW-1:0] d);
        return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {13'd0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run against the model; optional stray start pulse at iteration pulse_at
    task automatic run_check(input logic [PIW-1:0] s, input int n, input int pulse_at, input string tag);
        logic [PIW-1:0] vecs[$];
        logic [PIW-1:0] v;
        logic [PIW-1:0] exp_pi;
        logic [MW-1:0]  sig;
        v   = (s == '0) ? PIW'(1) : s;
        sig = '0;
        for (int i = 0; i < n; i++) begin
            vecs.push_back(v);
            sig = ref_misr(sig, v[2:0]);
            v   = ref_lfsr(v);
        end
        seed        = s;
        num_vectors = CW'(n);
        start       = 1'b1;
        tick();
        start = 1'b0;
        if (n > 0) begin
            for (int i = 0; i <= n; i++) begin
                exp_pi = vecs[(i < n) ? i : n - 1];
                checks++;
                if (pi !== exp_pi) begin
                    errors++;
                    $display("FAIL %s pi[%0d]: got %h want %h", tag, i, pi, exp_pi);
                end
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy/done[%0d]: got %b/%b want 1/0", tag, i, busy, done);
                end
                checks++;
                if (vec_count !== CW'(i)) begin
                    errors++;
                    $display("FAIL %s vec_count[%0d]: got %0d want %0d", tag, i, vec_count, i);
                end
                if (i == pulse_at) begin
                    start       = 1'b1;
                    seed        = PIW'({$urandom, $urandom});
                    num_vectors = CW'($urandom_range(0, 50));
                end
                tick();
                start = 1'b0;
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s final busy/done: got %b/%b want 0/1", tag, busy, done);
        end
        checks++;
        if (signature !== sig) begin
            errors++;
            $display("FAIL %s signature: got %h want %h", tag, signature, sig);
        end
        checks++;
        if (vec_count !== CW'(n)) begin
            errors++;
            $display("FAIL %s final vec_count: got %0d want %0d", tag, vec_count, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (pi !== '0 || busy !== 1'b0 || done !== 1'b0 || signature !== '0 || vec_count !== '0) begin
            errors++;
            $display("FAIL reset_values: got pi=%h busy=%b done=%b sig=%h cnt=%0d want all 0",
                     pi, busy, done, signature, vec_count);
        end
        // Mid-run asynchronous reset
        seed = PIW'(5); num_vectors = CW'(4); start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pi !== '0 || busy !== 1'b0 || done !== 1'b0 || signature !== '0 || vec_count !== '0) begin
            errors++;
            $display("FAIL async_reset: got pi=%h busy=%b done=%b sig=%h cnt=%0d want all 0",
                     pi, busy, done, signature, vec_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_count !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b cnt=%0d want 0/0/0", busy, done, vec_count);
        end
    endtask

    task automatic test_sequence();
        logic [PIW-1:0] exp_seq[6];
        exp_seq = '{38'h1, 38'h3, 38'h7, 38'hF, 38'h1F, 38'h3E};
        seed = PIW'(1); num_vectors = CW'(6); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (pi !== exp_seq[i]) begin
                errors++;
                $display("FAIL seq_pi[%0d]: got %h want %h", i, pi, exp_seq[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b0 || vec_count !== CW'(6) || pi !== 38'h3E) begin
            errors++;
            $display("FAIL seq_edge6: got done=%b cnt=%0d pi=%h want 0/6/3e", done, vec_count, pi);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || vec_count !== CW'(6)) begin
            errors++;
            $display("FAIL seq_done: got done=%b busy=%b cnt=%0d want 1/0/6", done, busy, vec_count);
        end
    endtask

    task automatic test_signature();
        run_check(PIW'(1), 3, -1, "sig_n3");
        checks++;
        if (signature !== 16'h0005) begin
            errors++;
            $display("FAIL sig_n3_const: got %h want 0005", signature);
        end
        run_check(PIW'(1), 1, -1, "sig_n1");
        checks++;
        if (signature !== 16'h0001) begin
            errors++;
            $display("FAIL sig_n1_const: got %h want 0001", signature);
        end
    endtask

    task automatic test_zero_count();
        seed = PIW'(1); num_vectors = '0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || signature !== '0 || vec_count !== '0) begin
            errors++;
            $display("FAIL zero_n: got done=%b busy=%b sig=%h cnt=%0d want 1/0/0000/0",
                     done, busy, signature, vec_count);
        end
    endtask

    task automatic test_zero_seed_and_ignore();
        run_check('0, 1, -1, "zero_seed");
        run_check('0, 5, 1, "start_in_run");
        run_check(PIW'(9), 4, 4, "start_in_drain");
    endtask

    task automatic test_reset_then_restart();
        seed = PIW'(1); num_vectors = CW'(6); start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (vec_count !== CW'(2)) begin
            errors++;
            $display("FAIL abort_cnt: got %0d want 2", vec_count);
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_check(PIW'(1), 3, -1, "after_abort");
        checks++;
        if (signature !== 16'h0005) begin
            errors++;
            $display("FAIL after_abort_const: got %h want 0005", signature);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            run_check(PIW'({$urandom, $urandom}), int'($urandom_range(1, 40)),
                      int'($urandom_range(0, 45)), $sformatf("rand%0d", k));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        seed        = '0;
        num_vectors = '0;
        test_reset();
        test_sequence();
        test_signature();
        test_zero_count();
        test_zero_seed_and_ignore();
        test_reset_then_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
